// File: rtl/mux_sel_pkg.sv
// Shared defaults, helper and output-state type for the registered N-way selector.
package mux_sel_pkg;

  localparam int unsigned MUX_W_DEF         = 32;
  localparam int unsigned MUX_N_DEF         = 5;
  localparam int unsigned MUX_SEL_W_DEF     = 3;
  localparam int unsigned MUX_CNT_W_DEF     = 8;
  localparam int unsigned MUX_CONST_IDX_DEF = 1;
  localparam logic [31:0] MUX_CONST_VAL_DEF = 32'd4;

  // Minimum select width able to address n channels (at least one bit).
  function automatic int unsigned sel_w_de_n(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational N-way indexed select of a flattened bus, plus in-range flag.
// MUX_SEL_CONST_INJECT_EN: channel CONST_IDX drives CONST_VAL instead of its slice.
module mux_sel_comb
  import mux_sel_pkg::*;
#(
  parameter int unsigned W         = MUX_W_DEF,
  parameter int unsigned N         = MUX_N_DEF,
  parameter int unsigned SEL_W     = sel_w_de_n(MUX_N_DEF),
  parameter int unsigned CONST_IDX = MUX_CONST_IDX_DEF,
  parameter logic [W-1:0] CONST_VAL = W'(MUX_CONST_VAL_DEF)
) (
  input  logic [N*W-1:0] entradas,
  input  logic [SEL_W-1:0] controle,
  output logic [W-1:0]   valor,
  output logic           em_faixa
);

`ifdef MUX_SEL_CONST_INJECT_EN
  localparam bit INJETA = 1'b1;
`else
  localparam bit INJETA = 1'b0;
`endif

  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N);

  // Range check and indexed select; out-of-range selects yield zero.
  always_comb begin
    valor    = '0;
    em_faixa = ({1'b0, controle} < N_LIM);
    for (int unsigned i = 0; i < N; i++) begin
      if (controle == SEL_W'(i)) begin
        if (INJETA && (i == CONST_IDX)) begin
          valor = CONST_VAL;
        end else begin
          valor = entradas[i*W +: W];
        end
      end
    end
  end

endmodule

// File: rtl/mux_sel_reg.sv
// Registered N-way W-bit selector with valid/ready handshake, sticky
// invalid-select flag and saturating invalid-select counter.
// Optional build macro: MUX_SEL_CONST_INJECT_EN (constant on channel CONST_IDX).
module mux_sel_reg
  import mux_sel_pkg::*;
#(
  parameter int unsigned W         = MUX_W_DEF,
  parameter int unsigned N         = MUX_N_DEF,
  parameter int unsigned SEL_W     = sel_w_de_n(MUX_N_DEF),
  parameter int unsigned CNT_W     = MUX_CNT_W_DEF,
  parameter int unsigned CONST_IDX = MUX_CONST_IDX_DEF,
  parameter logic [W-1:0] CONST_VAL = W'(MUX_CONST_VAL_DEF)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N*W-1:0]   entradas,
  input  logic [SEL_W-1:0] controle,
  input  logic             valido_in,
  output logic             pronto_in,
  output logic [W-1:0]     saida,
  output logic             valido_out,
  input  logic             pronto_out,
  output logic             erro_sel,
  output logic [CNT_W-1:0] cont_erro,
  input  logic             limpa_erro
);

  logic [W-1:0]     w_valor;
  logic             w_em_faixa;
  logic             w_aceita;
  logic             w_consome;

  estado_t          r_estado, w_estado_prox;
  logic [W-1:0]     r_saida, w_saida_prox;
  logic             r_erro, w_erro_prox;
  logic [CNT_W-1:0] r_cont, w_cont_prox;

  mux_sel_comb #(
    .W         (W),
    .N         (N),
    .SEL_W     (SEL_W),
    .CONST_IDX (CONST_IDX),
    .CONST_VAL (CONST_VAL)
  ) u_sel (
    .entradas (entradas),
    .controle (controle),
    .valor    (w_valor),
    .em_faixa (w_em_faixa)
  );

  assign valido_out = (r_estado == CHEIO);
  assign pronto_in  = !valido_out || pronto_out;
  assign w_aceita   = valido_in && pronto_in;
  assign w_consome  = valido_out && pronto_out;
  assign saida      = r_saida;
  assign erro_sel   = r_erro;
  assign cont_erro  = r_cont;

  // Next output state/data and error bookkeeping; limpa_erro wins over a new error.
  always_comb begin
    w_estado_prox = r_estado;
    w_saida_prox  = r_saida;
    w_erro_prox   = r_erro;
    w_cont_prox   = r_cont;

    if (w_aceita && w_em_faixa) begin
      w_estado_prox = CHEIO;
      w_saida_prox  = w_valor;
    end else if (w_aceita) begin
      // An accept implies the stage is empty or being drained, so it ends empty.
      w_estado_prox = VAZIO;
    end else if (w_consome) begin
      w_estado_prox = VAZIO;
    end

    if (limpa_erro) begin
      w_erro_prox = 1'b0;
      w_cont_prox = '0;
    end else if (w_aceita && !w_em_faixa) begin
      w_erro_prox = 1'b1;
      if (r_cont != '1) begin
        w_cont_prox = r_cont + 1'b1;
      end
    end
  end

  // State, data and error registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado <= VAZIO;
      r_saida  <= '0;
      r_erro   <= 1'b0;
      r_cont   <= '0;
    end else begin
      r_estado <= w_estado_prox;
      r_saida  <= w_saida_prox;
      r_erro   <= w_erro_prox;
      r_cont   <= w_cont_prox;
    end
  end

endmodule

// File: tb/tb_mux_sel_reg.sv
// Self-checking bench for mux_sel_reg: scoreboard of accepted values plus a
// cycle model of the handshake and error flag, and directed checks.
module tb_mux_sel_reg;

  localparam int unsigned W = 32;
  localparam int unsigned N = 5;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 8;

  logic             clock;
  logic             reset;
  logic [N*W-1:0]   entradas;
  logic [SEL_W-1:0] controle;
  logic             valido_in;
  logic             pronto_in;
  logic [W-1:0]     saida;
  logic             valido_out;
  logic             pronto_out;
  logic             erro_sel;
  logic [CNT_W-1:0] cont_erro;
  logic             limpa_erro;

  int n_asser  = 0;
  int n_falhas = 0;

  logic [W-1:0] fila[$];
  logic         mdl_ok     = 1'b0;
  logic         mdl_valido;
  logic         mdl_erro;
  logic [7:0]   mdl_cont;

  mux_sel_reg #(
    .W         (W),
    .N         (N),
    .SEL_W     (SEL_W),
    .CNT_W     (CNT_W),
    .CONST_IDX (1),
    .CONST_VAL (32'd4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .entradas   (entradas),
    .controle   (controle),
    .valido_in  (valido_in),
    .pronto_in  (pronto_in),
    .saida      (saida),
    .valido_out (valido_out),
    .pronto_out (pronto_out),
    .erro_sel   (erro_sel),
    .cont_erro  (cont_erro),
    .limpa_erro (limpa_erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_asser++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: obtido=0x%0h esperado=0x%0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  function automatic logic [W-1:0] canal_esperado(input logic [SEL_W-1:0] c);
    logic [W-1:0] v;
    int idx;
    idx = int'(c);
    v = entradas[idx*W +: W];
`ifdef MUX_SEL_CONST_INJECT_EN
    if (idx == 1) v = 32'd4;
`endif
    return v;
  endfunction

  // Cycle model: compare current outputs, then predict the effect of the coming edge.
  always @(negedge clock) begin
    logic aceita;
    logic dentro;
    if (mdl_ok) begin
      verifica("valido_out", {31'd0, valido_out}, {31'd0, mdl_valido});
      verifica("erro_sel", {31'd0, erro_sel}, {31'd0, mdl_erro});
      verifica("cont_erro", {24'd0, cont_erro}, {24'd0, mdl_cont});
      verifica("pronto_in", {31'd0, pronto_in}, {31'd0, (!mdl_valido || pronto_out)});
    end
    if (!reset) begin
      fila.delete();
      mdl_valido = 1'b0;
      mdl_erro   = 1'b0;
      mdl_cont   = 8'd0;
      mdl_ok     = 1'b1;
    end else if (mdl_ok) begin
      aceita = valido_in && (!mdl_valido || pronto_out);
      dentro = (int'(controle) < N);
      if (mdl_valido && pronto_out) begin
        if (fila.size() == 0) begin
          verifica("fila_vazia", saida, 32'hFFFF_FFFF);
        end else begin
          verifica("dado", saida, fila.pop_front());
        end
      end
      if (aceita && dentro) begin
        fila.push_back(canal_esperado(controle));
        mdl_valido = 1'b1;
      end else if (aceita || (mdl_valido && pronto_out)) begin
        mdl_valido = 1'b0;
      end
      if (limpa_erro) begin
        mdl_erro = 1'b0;
        mdl_cont = 8'd0;
      end else if (aceita && !dentro) begin
        mdl_erro = 1'b1;
        if (mdl_cont != 8'hFF) mdl_cont = mdl_cont + 8'd1;
      end
    end
  end

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic confere(input string tag, input logic [31:0] s, input logic v,
                         input logic e, input logic [7:0] c);
    verifica({tag, ".saida"}, saida, s);
    verifica({tag, ".valido"}, {31'd0, valido_out}, {31'd0, v});
    verifica({tag, ".erro"}, {31'd0, erro_sel}, {31'd0, e});
    verifica({tag, ".cont"}, {24'd0, cont_erro}, {24'd0, c});
  endtask

  initial begin
    reset      = 1'b0;
    entradas   = {32'h50, 32'h40, 32'h30, 32'h20, 32'h10};
    controle   = '0;
    valido_in  = 1'b0;
    pronto_out = 1'b1;
    limpa_erro = 1'b0;
    ciclo();
    ciclo();
    confere("reset", 32'h0, 1'b0, 1'b0, 8'd0);
    reset = 1'b1;

    // Basic valid select, one-cycle latency.
    controle = 3'd3; valido_in = 1'b1;
    ciclo();
    valido_in = 1'b0;
    confere("sel3", 32'h40, 1'b1, 1'b0, 8'd0);

    // Invalid select: output holds, flag and counter set, then saturation.
    controle = 3'd6; valido_in = 1'b1;
    ciclo();
    confere("inval1", 32'h40, 1'b0, 1'b1, 8'd1);
    for (int i = 1; i < 300; i++) ciclo();
    valido_in = 1'b0;
    confere("satura", 32'h40, 1'b0, 1'b1, 8'd255);
    limpa_erro = 1'b1;
    ciclo();
    limpa_erro = 1'b0;
    confere("limpa", 32'h40, 1'b0, 1'b0, 8'd0);

    // Stall holds the pending value and blocks upstream.
    controle = 3'd1; valido_in = 1'b1;
    ciclo();
    confere("carga20", 32'h20, 1'b1, 1'b0, 8'd0);
    pronto_out = 1'b0; controle = 3'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      verifica("stall.pronto_in", {31'd0, pronto_in}, 32'd0);
      ciclo();
      verifica("stall.saida", saida, 32'h20);
    end
    pronto_out = 1'b1;
    ciclo();
    confere("libera", 32'h50, 1'b1, 1'b0, 8'd0);

    // Back-to-back accepts with no bubbles.
    controle = 3'd0; ciclo(); confere("b2b0", 32'h10, 1'b1, 1'b0, 8'd0);
    controle = 3'd2; ciclo(); confere("b2b2", 32'h30, 1'b1, 1'b0, 8'd0);
    controle = 3'd4; ciclo(); confere("b2b4", 32'h50, 1'b1, 1'b0, 8'd0);
    valido_in = 1'b0;
    ciclo();

    // Channel 1 is the injected constant only when the option is built in.
    entradas[1*W +: W] = 32'hDEAD;
    controle = 3'd1; valido_in = 1'b1;
    ciclo();
    valido_in = 1'b0;
`ifdef MUX_SEL_CONST_INJECT_EN
    verifica("injeta", saida, 32'h4);
`else
    verifica("injeta", saida, 32'hDEAD);
`endif
    ciclo();

    // Reset during a stall discards the pending value and the error state.
    controle = 3'd7; valido_in = 1'b1;
    ciclo();
    controle = 3'd2;
    ciclo();
    valido_in = 1'b0; pronto_out = 1'b0;
    confere("pre_reset", 32'h30, 1'b1, 1'b1, 8'd1);
    ciclo();
    reset = 1'b0;
    ciclo();
    reset = 1'b1;
    confere("reset_stall", 32'h0, 1'b0, 1'b0, 8'd0);
    pronto_out = 1'b1;

    // Clear has priority over a same-cycle invalid accept.
    controle = 3'd5; valido_in = 1'b1;
    ciclo();
    confere("erro5", 32'h0, 1'b0, 1'b1, 8'd1);
    controle = 3'd6; limpa_erro = 1'b1;
    ciclo();
    valido_in = 1'b0; limpa_erro = 1'b0;
    confere("limpa_prio", 32'h0, 1'b0, 1'b0, 8'd0);

    ciclo();
    ciclo();
    verifica("fila_final", fila.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asser, n_falhas);
    $finish;
  end

endmodule

// File: doc/mux_sel_reg.md
Name: mux_sel_reg

Overview:
- Parametrised successor to the datapath 5-way, 32-bit source selectors: N-input, W-bit selector with a registered output stage and a valid/ready handshake.
- Feeds ALU-operand and PC-source paths where the selected value must be held across stalls.
- Out-of-range selects are detected: the output holds its last value, a sticky error flag is raised and invalid selects are counted.

Parameters:
- W, 32, data width of each input and the output
- N, 5, number of input channels (2..16)
- SEL_W, 3, width of controle; must satisfy 2**SEL_W >= N
- CNT_W, 8, width of the invalid-select counter
- CONST_IDX, 1, channel replaced by a constant when CONST_INJECT_EN is defined
- CONST_VAL, 32'd4, constant driven on channel CONST_IDX when CONST_INJECT_EN is defined

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- entradas  in  N*W  flattened inputs; channel i = entradas[i*W +: W]
- controle  in  SEL_W  channel select, sampled with valido_in
- valido_in  in  1  upstream request valid
- pronto_in  out  1  block can accept a request
- saida  out  W  registered selected value
- valido_out  out  1  saida holds a new, unconsumed value
- pronto_out  in  1  downstream accepts saida
- erro_sel  out  1  sticky: an accepted request had controle >= N
- cont_erro  out  CNT_W  saturating count of invalid accepted requests
- limpa_erro  in  1  clears erro_sel and cont_erro

Behaviour:
- Reset: sampled only on a rising clock edge while reset = 0. saida = 0, valido_out = 0, erro_sel = 0, cont_erro = 0.
- pronto_in = !valido_out || pronto_out (single-stage pipeline; combinational backpressure pass-through).
- Accept: valido_in && pronto_in at a clock edge.
- Valid select on accept (controle < N): saida <= selected channel and valido_out <= 1. Latency is 1 cycle.
- Invalid select on accept (controle >= N):
  - saida holds its previous value; valido_out <= 0.
  - erro_sel <= 1; cont_erro increments, saturating at all-ones.
- No accept, output consumed (valido_out && pronto_out): valido_out <= 0; saida holds.
- Stall (valido_out && !pronto_out): saida and valido_out hold; pronto_in = 0.
- Accept and consume in the same cycle: the new value replaces the old one and valido_out stays 1. No bubble.
- limpa_erro has priority over a same-cycle invalid accept: erro_sel = 0 and cont_erro = 0 after the edge.
- Reset during a stall discards the pending value.
- Output states: VAZIO (valido_out = 0) and CHEIO (valido_out = 1).
  - VAZIO -> CHEIO on a valid accept.
  - CHEIO -> VAZIO on a consume with no valid accept.
  - CHEIO stays CHEIO on a stall, or on a consume together with a valid accept.
- No `initial` blocks; reset is the only initialisation.

Optional Feature:
- MUX_SEL_CONST_INJECT_EN defined: channel CONST_IDX ignores its entradas slice and drives CONST_VAL (PC+4 source). The slice is left unused.
- Undefined: all N channels come from entradas; CONST_IDX and CONST_VAL are unused.

Decomposition:
- Package mux_sel_pkg holds:
  - default W, N, SEL_W and CNT_W constants
  - CONST_VAL default
  - SEL_W-from-N helper function
  - state typedef {VAZIO, CHEIO}
- One sub-module: mux_sel_comb, the combinational N-way indexed select of the flattened bus including constant injection. It also produces the in-range flag.
- The register, handshake and error logic stay in mux_sel_reg.

Test Plan:
- Defaults; entradas ch0..ch4 = 0x10,0x20,0x30,0x40,0x50; controle = 3, valido_in = 1, pronto_out = 1 -> next cycle saida = 0x40, valido_out = 1, erro_sel = 0.
- controle = 6 accepted while saida = 0x40 -> saida stays 0x40, valido_out = 0, erro_sel = 1, cont_erro = 1. Repeat 300 times with CNT_W = 8 -> cont_erro = 255.
- pronto_out = 0 after saida = 0x20 loaded; drive controle = 4 for 3 cycles -> pronto_in = 0, saida stays 0x20. Release pronto_out -> saida = 0x50 the next cycle.
- Back-to-back accepts controle = 0,2,4 with pronto_out = 1 -> saida sequence 0x10, 0x30, 0x50 with no bubbles.
- MUX_SEL_CONST_INJECT_EN defined, controle = 1, entradas ch1 = 0xDEAD -> saida = 0x4. Undefined -> saida = 0xDEAD.
- Assert reset = 0 mid-stall with saida = 0x30 -> after the edge saida = 0, valido_out = 0, erro_sel = 0, cont_erro = 0. limpa_erro with a same-cycle invalid select -> erro_sel = 0.
